// File: rtl/modem_defn_pkg.sv
// rtl/modem_defn_pkg.sv - shared receive-path constants and capture FSM state type
package modem_defn_pkg;
    localparam int ADC_WIDTH   = 14;
    localparam int LARGO_TONO  = 500;
    localparam int CLK_FREQ_HZ = 125_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLDOFF = 2'd2
    } cap_state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO
module sync_fifo_fwft #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (count_q != CW'(DEPTH));
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/adc_burst_packetizer.sv
// rtl/adc_burst_packetizer.sv - threshold-triggered ADC burst capture into framed packets
module adc_burst_packetizer #(
    parameter int ADC_WIDTH  = modem_defn_pkg::ADC_WIDTH,
    parameter int PKT_LEN    = modem_defn_pkg::LARGO_TONO,
    parameter int THRESH     = 2048,
    parameter int HOLDOFF    = 16,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [ADC_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [15:0]          pkt_count,
    output logic                 overflow,
    output logic                 busy
);
    import modem_defn_pkg::cap_state_t;
    import modem_defn_pkg::ST_IDLE;
    import modem_defn_pkg::ST_CAPTURE;
    import modem_defn_pkg::ST_HOLDOFF;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(PKT_LEN + 1);
    localparam int QW = $clog2(HOLDOFF + 1);

    if (FIFO_DEPTH < PKT_LEN) begin : g_bad_depth
        $error("adc_burst_packetizer: FIFO_DEPTH must be >= PKT_LEN");
    end

    cap_state_t           state_q;
    logic [ADC_WIDTH-1:0] in_data_q;
    logic                 in_valid_q;
    logic [ADC_WIDTH-1:0] in_abs;
    logic                 trig;
    logic [SW-1:0]        samp_cnt_q;
    logic [QW-1:0]        quiet_q;
    logic                 push_q;
    logic                 push_last_q;
    logic [ADC_WIDTH-1:0] push_data_q;
    logic                 busy_q;
    logic                 overflow_q;
    logic [15:0]          pkt_count_q;

    logic [ADC_WIDTH:0]   fifo_rd;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_pop;
    logic [CW:0]          occ_eff;
    logic                 room_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
        end else begin
            in_data_q  <= adc_data;
            in_valid_q <= adc_valid;
        end
    end

    // Unsigned magnitude: the most negative code maps to 2^(W-1), which still fits.
    assign in_abs = in_data_q[ADC_WIDTH-1] ? (~in_data_q + ADC_WIDTH'(1)) : in_data_q;
    assign trig   = (in_abs >= ADC_WIDTH'(THRESH));

    // Occupancy seen by the trigger counts a write still in flight and this cycle's pop.
    assign fifo_pop = m_valid && m_ready;
    assign occ_eff  = {1'b0, fifo_count} + (CW+1)'(push_q) - (CW+1)'(fifo_pop);
    assign room_ok  = (occ_eff <= (CW+1)'(FIFO_DEPTH - PKT_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            samp_cnt_q  <= '0;
            quiet_q     <= '0;
            push_q      <= 1'b0;
            push_last_q <= 1'b0;
            push_data_q <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            push_last_q <= 1'b0;
            push_data_q <= in_data_q;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_q && en && trig) begin
                        busy_q  <= 1'b1;
                        quiet_q <= '0;
                        if (room_ok) begin
                            push_q      <= 1'b1;
                            push_last_q <= (PKT_LEN == 1);
                            samp_cnt_q  <= SW'(1);
                            state_q     <= (PKT_LEN == 1) ? ST_HOLDOFF : ST_CAPTURE;
                        end else begin
                            overflow_q <= 1'b1;
                            state_q    <= ST_HOLDOFF;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (in_valid_q) begin
                        push_q     <= 1'b1;
                        samp_cnt_q <= samp_cnt_q + SW'(1);
                        if (samp_cnt_q == SW'(PKT_LEN - 1)) begin
                            push_last_q <= 1'b1;
                            samp_cnt_q  <= '0;
                            quiet_q     <= '0;
                            state_q     <= ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (in_valid_q) begin
                        if (trig) begin
                            quiet_q <= '0;
                        end else if (quiet_q == QW'(HOLDOFF - 1)) begin
                            quiet_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            quiet_q <= quiet_q + QW'(1);
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ADC_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_q),
        .push_data_i ({push_last_q, push_data_q}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else if (fifo_pop && m_last) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_empty ? '0 : fifo_rd[ADC_WIDTH-1:0];
    assign m_last    = !fifo_empty && fifo_rd[ADC_WIDTH];
    assign pkt_count = pkt_count_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
endmodule

// File: doc/adc_burst_packetizer.md
# adc_burst_packetizer

Sits directly downstream of the 14-bit ADC interface in the modem receive path. Watches the continuous two's-complement sample stream for a tone burst by amplitude threshold. On detection it captures exactly PKT_LEN consecutive valid samples into an internal FIFO. It emits them as a framed packet on a valid/ready stream with a last marker, and counts delivered packets.

## Interface
Parameters:
- ADC_WIDTH, 14, sample width, signed two's complement.
- PKT_LEN, 500, samples per packet (tone length).
- THRESH, 2048, trigger level on |sample|, unsigned, ADC_WIDTH bits.
- HOLDOFF, 16, consecutive sub-threshold valid samples required before re-arming.
- FIFO_DEPTH, 512, entries; must satisfy FIFO_DEPTH >= PKT_LEN (elaboration-time assertion).

Ports:
- clk  in  1  single clock, 125 MHz.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arms triggering; sampled only in IDLE.
- adc_data  in  ADC_WIDTH  ADC sample, signed.
- adc_valid  in  1  sample qualifier.
- m_data  out  ADC_WIDTH  packet sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  final sample of packet.
- pkt_count  out  16  packets fully delivered; wraps at 2^16.
- overflow  out  1  sticky: a burst trigger was rejected for lack of FIFO space.
- busy  out  1  FSM not in IDLE.

## Operation
- Input stage registers adc_data/adc_valid once. The FSM acts on the registered sample.
- |x| is computed into ADC_WIDTH unsigned bits; |-8192| = 8192. Trigger condition: |x| >= THRESH.
- FSM states are IDLE, CAPTURE, HOLDOFF.
- IDLE, on valid && en && trigger:
  - If FIFO free >= PKT_LEN: write this sample, sample counter = 1, go to CAPTURE.
  - Otherwise: write nothing, set overflow, go to HOLDOFF.
- CAPTURE: write every valid sample, whatever its amplitude. The PKT_LEN-th write carries last=1, then go to HOLDOFF. Invalid cycles write nothing and do not advance the counter. en is ignored here.
- HOLDOFF: a quiet counter increments on each valid sub-threshold sample and clears on each valid above-threshold sample. Go to IDLE when it reaches HOLDOFF.
- FIFO entry is {last, data}. Reservation at trigger guarantees that a write never hits a full FIFO.
- Output is first-word-fall-through:
  - m_valid = FIFO not empty.
  - m_data/m_last hold stable while m_valid && !m_ready.
- pkt_count increments on m_valid && m_ready && m_last.
- Free-space check uses the occupancy of the current cycle, including a simultaneous pop.

## Timing
- Reset values:
  - Outputs: m_valid=0, m_last=0, m_data=0, pkt_count=0, overflow=0, busy=0.
  - Internal: FSM=IDLE, FIFO empty, all counters 0.
- Reset mid-packet discards FIFO contents. No partial packet appears after rst deasserts.
- Latency: a sample presented at edge N has m_valid visible after edge N+2, if the FIFO was empty.
- Throughput: one sample per clock in and out.
- Simultaneous push and pop leaves occupancy unchanged. Pop on empty is ignored.
- busy rises on the edge that leaves IDLE. It falls on the edge that enters IDLE.
- overflow clears only on rst.

## Structure
- Shared package modem_defn_pkg holds:
  - ADC_WIDTH and LARGO_TONO (the default for PKT_LEN).
  - CLK_FREQ_HZ.
  - The FSM state enum, typedef cap_state_t.
- One sub-module: sync_fifo_fwft, parameterised by width (ADC_WIDTH+1) and depth. It exposes a push/pop/empty/count interface.
- FSM, abs/threshold logic and counters live in the top.

## Test plan
1. Tone 37.21 MHz, amplitude 6000, after 20 zero samples, m_ready=1:
   - Exactly 500 output beats; m_last only on beat 500.
   - Beat 1 equals the first input with |x| >= 2048.
   - pkt_count=1, overflow=0.
2. Same tone at amplitude 2000 -> no m_valid ever, busy stays 0.
3. Edge values: lone samples 2047 then 2048 with zeros around them -> trigger on 2048 only. Repeat with -8192 -> it triggers.
4. m_ready=0; two 500-sample bursts separated by 100 zeros:
   - First burst captured; second rejected; overflow=1.
   - Then m_ready=1 -> 500 beats, pkt_count=1.
5. Continuous 600-sample burst, then 16 zeros, then a new burst:
   - Exactly 2 packets of 500.
   - Trailing 100 burst samples are not captured.
6. rst for 10 cycles at captured sample 250, then 500-sample burst:
   - Outputs at reset values on the edge after rst.
   - Afterwards exactly one clean 500-beat packet; pkt_count=1.
